// File: rtl/ecc_point_unit_if.sv
// Request/result bundle between the scalar-multiply controller and ecc_point_unit.
// o_err is present only when ECC_PT_CHECK_EN is defined.
interface ecc_point_unit_if #(
    parameter int WIDTH = 4
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_prime;
    logic [WIDTH-1:0] i_x1;
    logic [WIDTH-1:0] i_y1;
    logic             i_inf1;
    logic [WIDTH-1:0] i_x2;
    logic [WIDTH-1:0] i_y2;
    logic             i_inf2;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_x3;
    logic [WIDTH-1:0] o_y3;
    logic             o_inf3;
`ifdef ECC_PT_CHECK_EN
    logic             o_err;

    modport master (output i_start, i_a, i_prime, i_x1, i_y1, i_inf1, i_x2, i_y2, i_inf2,
                    input  o_busy, o_done, o_x3, o_y3, o_inf3, o_err);
    modport slave  (input  i_start, i_a, i_prime, i_x1, i_y1, i_inf1, i_x2, i_y2, i_inf2,
                    output o_busy, o_done, o_x3, o_y3, o_inf3, o_err);
`else
    modport master (output i_start, i_a, i_prime, i_x1, i_y1, i_inf1, i_x2, i_y2, i_inf2,
                    input  o_busy, o_done, o_x3, o_y3, o_inf3);
    modport slave  (input  i_start, i_a, i_prime, i_x1, i_y1, i_inf1, i_x2, i_y2, i_inf2,
                    output o_busy, o_done, o_x3, o_y3, o_inf3);
`endif
endinterface

// File: rtl/ecc_point_unit.sv
// Sequential GF(p) point add/double engine built around one bit-serial modular multiplier.
// Define ECC_PT_CHECK_EN to add operand range checking and the o_err result flag.
module ecc_point_unit #(
    parameter int WIDTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    ecc_point_unit_if.slave bus
);
    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO_W  = WIDTH'(2);

    typedef enum logic [2:0] {ST_IDLE, ST_CLASSIFY, ST_MM_SETUP, ST_MM_ITER, ST_DONE} state_t;
    typedef enum logic [2:0] {PH_SQ1, PH_INV_SQ, PH_INV_MUL, PH_LAM, PH_X3, PH_Y3} phase_t;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] p);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        else                s = s;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] p);
        logic [WIDTH:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + {1'b0, p} - {1'b0, y};
        return s[WIDTH-1:0];
    endfunction

    // One MSB-first step: acc <- 2*acc (+ a when the multiplier bit is set), kept below p.
    function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] acc, input logic [WIDTH-1:0] a,
                                                 input logic b_bit, input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] d;
        d = mod_add(acc, acc, p);
        if (b_bit) return mod_add(d, a, p);
        else       return d;
    endfunction

    state_t           state_r, state_next_s;
    phase_t           phase_r;
    logic [WIDTH-1:0] a_r, p_r, x1_r, y1_r, x2_r, y2_r;
    logic             inf1_r, inf2_r;
    logic [WIDTH-1:0] num_r, den_r, inv_r, lam_r, x3_r;
    logic [WIDTH-1:0] mm_a_r, mm_b_r, acc_r;
    logic [CW-1:0]    cnt_r, ebit_r;
    logic [WIDTH-1:0] out_x_r, out_y_r;
    logic             out_inf_r, busy_r, done_r;
    logic [WIDTH-1:0] acc_next_s, opa_s, opb_s, exp_s;
    logic             chk_flag_s, ld_out_s, res_inf_s;
    logic [WIDTH-1:0] res_x_s, res_y_s;

    assign acc_next_s = mm_step(acc_r, mm_a_r, mm_b_r[cnt_r], p_r);
    assign exp_s      = p_r - TWO_W;

`ifdef ECC_PT_CHECK_EN
    localparam logic [WIDTH-1:0] THREE_W = WIDTH'(3);
    logic err_r, res_err_s;
    assign chk_flag_s = (p_r < THREE_W) || (a_r >= p_r) ||
                        (!inf1_r && ((x1_r >= p_r) || (y1_r >= p_r))) ||
                        (!inf2_r && ((x2_r >= p_r) || (y2_r >= p_r)));
    assign bus.o_err  = err_r;
`else
    assign chk_flag_s = 1'b0;
`endif

    // Multiplier operand selection for the current phase
    always_comb begin
        opa_s = inv_r;
        opb_s = inv_r;
        case (phase_r)
            PH_SQ1:     begin opa_s = x1_r;  opb_s = x1_r;  end
            PH_INV_SQ:  begin opa_s = inv_r; opb_s = inv_r; end
            PH_INV_MUL: begin opa_s = inv_r; opb_s = den_r; end
            PH_LAM:     begin opa_s = num_r; opb_s = inv_r; end
            PH_X3:      begin opa_s = lam_r; opb_s = lam_r; end
            PH_Y3:      begin opa_s = lam_r; opb_s = mod_sub(x1_r, x3_r, p_r); end
            default:    begin opa_s = inv_r; opb_s = inv_r; end
        endcase
    end

    // Next-state decode plus the result to load when entering DONE
    always_comb begin
        state_next_s = state_r;
        ld_out_s     = 1'b0;
        res_x_s      = ZERO_W;
        res_y_s      = ZERO_W;
        res_inf_s    = 1'b0;
`ifdef ECC_PT_CHECK_EN
        res_err_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) state_next_s = ST_CLASSIFY;
                else             state_next_s = ST_IDLE;
            end
            ST_CLASSIFY: begin
                if (chk_flag_s) begin
                    state_next_s = ST_DONE;
                    ld_out_s     = 1'b1;
                    res_inf_s    = 1'b1;
`ifdef ECC_PT_CHECK_EN
                    res_err_s    = 1'b1;
`endif
                end else if (inf1_r) begin
                    state_next_s = ST_DONE;
                    ld_out_s     = 1'b1;
                    res_x_s      = x2_r;
                    res_y_s      = y2_r;
                    res_inf_s    = inf2_r;
                end else if (inf2_r) begin
                    state_next_s = ST_DONE;
                    ld_out_s     = 1'b1;
                    res_x_s      = x1_r;
                    res_y_s      = y1_r;
                end else if ((x1_r == x2_r) && ((y1_r != y2_r) || (y1_r == ZERO_W))) begin
                    state_next_s = ST_DONE;
                    ld_out_s     = 1'b1;
                    res_inf_s    = 1'b1;
                end else begin
                    state_next_s = ST_MM_SETUP;
                end
            end
            ST_MM_SETUP: state_next_s = ST_MM_ITER;
            ST_MM_ITER: begin
                if (cnt_r != CNT_ZERO) begin
                    state_next_s = ST_MM_ITER;
                end else if (phase_r == PH_Y3) begin
                    state_next_s = ST_DONE;
                    ld_out_s     = 1'b1;
                    res_x_s      = x3_r;
                    res_y_s      = mod_sub(acc_next_s, y1_r, p_r);
                end else begin
                    state_next_s = ST_MM_SETUP;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Operand capture, multiplier iterations and folding of each product into the next phase
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_r <= PH_SQ1;
            a_r <= ZERO_W;  p_r <= ZERO_W;  x1_r <= ZERO_W; y1_r <= ZERO_W;
            x2_r <= ZERO_W; y2_r <= ZERO_W; inf1_r <= 1'b0; inf2_r <= 1'b0;
            num_r <= ZERO_W; den_r <= ZERO_W; inv_r <= ZERO_W; lam_r <= ZERO_W; x3_r <= ZERO_W;
            mm_a_r <= ZERO_W; mm_b_r <= ZERO_W; acc_r <= ZERO_W;
            cnt_r <= CNT_ZERO; ebit_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        a_r  <= bus.i_a;  p_r  <= bus.i_prime;
                        x1_r <= bus.i_x1; y1_r <= bus.i_y1; inf1_r <= bus.i_inf1;
                        x2_r <= bus.i_x2; y2_r <= bus.i_y2; inf2_r <= bus.i_inf2;
                    end
                end
                ST_CLASSIFY: begin
                    inv_r  <= ONE_W;
                    ebit_r <= LAST_IDX;
                    if (x1_r == x2_r) begin
                        phase_r <= PH_SQ1;
                        den_r   <= mod_add(y1_r, y1_r, p_r);
                    end else begin
                        phase_r <= PH_INV_SQ;
                        num_r   <= mod_sub(y2_r, y1_r, p_r);
                        den_r   <= mod_sub(x2_r, x1_r, p_r);
                    end
                end
                ST_MM_SETUP: begin
                    mm_a_r <= opa_s;
                    mm_b_r <= opb_s;
                    acc_r  <= ZERO_W;
                    cnt_r  <= LAST_IDX;
                end
                ST_MM_ITER: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ZERO) begin
                        case (phase_r)
                            PH_SQ1: begin
                                num_r   <= mod_add(mod_add(mod_add(acc_next_s, acc_next_s, p_r),
                                                           acc_next_s, p_r), a_r, p_r);
                                phase_r <= PH_INV_SQ;
                            end
                            PH_INV_SQ: begin
                                inv_r   <= acc_next_s;
                                phase_r <= PH_INV_MUL;
                            end
                            PH_INV_MUL: begin
                                if (exp_s[ebit_r]) inv_r <= acc_next_s;
                                if (ebit_r == CNT_ZERO) begin
                                    phase_r <= PH_LAM;
                                end else begin
                                    ebit_r  <= ebit_r - CNT_ONE;
                                    phase_r <= PH_INV_SQ;
                                end
                            end
                            PH_LAM: begin
                                lam_r   <= acc_next_s;
                                phase_r <= PH_X3;
                            end
                            PH_X3: begin
                                x3_r    <= mod_sub(mod_sub(acc_next_s, x1_r, p_r), x2_r, p_r);
                                phase_r <= PH_Y3;
                            end
                            default: phase_r <= phase_r;
                        endcase
                    end
                end
                default: phase_r <= phase_r;
            endcase
        end
    end

    // Registered handshake and result outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_r <= 1'b0; done_r <= 1'b0; out_inf_r <= 1'b0;
            out_x_r <= ZERO_W; out_y_r <= ZERO_W;
`ifdef ECC_PT_CHECK_EN
            err_r <= 1'b0;
`endif
        end else begin
            done_r <= (state_next_s == ST_DONE);
            busy_r <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
            if (ld_out_s) begin
                out_x_r   <= res_x_s;
                out_y_r   <= res_y_s;
                out_inf_r <= res_inf_s;
            end
`ifdef ECC_PT_CHECK_EN
            if ((state_r == ST_IDLE) && bus.i_start) err_r <= 1'b0;
            else if (ld_out_s)                       err_r <= res_err_s;
`endif
        end
    end

    assign bus.o_busy = busy_r;
    assign bus.o_done = done_r;
    assign bus.o_x3   = out_x_r;
    assign bus.o_y3   = out_y_r;
    assign bus.o_inf3 = out_inf_r;
endmodule

// File: tb/tb_ecc_point_unit.sv
// Directed bench for ecc_point_unit: integer-arithmetic point model checked every cycle,
// plus hand-computed results and latencies on the p=11, a=1 curve.
module tb_ecc_point_unit;
    localparam int W       = 4;
    localparam int LAT_DBL = (2*W+4)*(W+1)+2;
    localparam int LAT_ADD = (2*W+3)*(W+1)+2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ecc_point_unit_if #(.WIDTH(W)) bus ();
    ecc_point_unit #(.WIDTH(W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int md(input int v, input int p);
        int r;
        r = v % p;
        if (r < 0) r += p;
        return r;
    endfunction

    function automatic int inv(input int d, input int p);
        for (int v = 1; v < p; v++) if (md(d * v, p) == 1) return v;
        return 0;
    endfunction

    // Textbook affine point addition over GF(p) with the engine's latency rules
    task automatic model(input int p, input int a, input int x1, input int y1, input int i1,
                         input int x2, input int y2, input int i2,
                         output int rx, output int ry, output int rinf, output int rerr, output int lat);
        int lam;
        rx = 0; ry = 0; rinf = 0; rerr = 0; lat = 2;
`ifdef ECC_PT_CHECK_EN
        if (p < 3 || a >= p || (i1 == 0 && (x1 >= p || y1 >= p)) || (i2 == 0 && (x2 >= p || y2 >= p))) begin
            rinf = 1; rerr = 1;
            return;
        end
`endif
        if (i1 != 0) begin
            rx = x2; ry = y2; rinf = i2;
        end else if (i2 != 0) begin
            rx = x1; ry = y1;
        end else if (x1 == x2 && (y1 != y2 || y1 == 0)) begin
            rinf = 1;
        end else begin
            if (x1 == x2) begin
                lam = md((3*x1*x1 + a) * inv(md(2*y1, p), p), p);
                lat = LAT_DBL;
            end else begin
                lam = md((y2 - y1) * inv(md(x2 - x1, p), p), p);
                lat = LAT_ADD;
            end
            rx = md(lam*lam - x1 - x2, p);
            ry = md(lam*(x1 - rx) - y1, p);
        end
    endtask

    bit m_known = 1'b0;
    bit m_pend  = 1'b0;
    int m_k, m_lat, m_x, m_y, m_inf, m_err;
    int h_x = 0, h_y = 0, h_inf = 0, h_err = 0;

    // Cycle-by-cycle comparison against the model's timing and held results
    always @(negedge clk) begin
        bit idle_now;
        idle_now = !m_pend;
        if (m_known) begin
            if (m_pend) begin
                m_k++;
                if (m_k == m_lat) begin
                    check("cmp_done", int'(bus.o_done), 1);
                    check("cmp_busy_at_done", int'(bus.o_busy), 0);
                    check("cmp_x3", int'(bus.o_x3), m_x);
                    check("cmp_y3", int'(bus.o_y3), m_y);
                    check("cmp_inf3", int'(bus.o_inf3), m_inf);
`ifdef ECC_PT_CHECK_EN
                    check("cmp_err", int'(bus.o_err), m_err);
`endif
                    h_x = m_x; h_y = m_y; h_inf = m_inf; h_err = m_err;
                    m_pend = 1'b0;
                end else begin
                    check("cmp_done_early", int'(bus.o_done), 0);
                    check("cmp_busy", int'(bus.o_busy), 1);
`ifdef ECC_PT_CHECK_EN
                    check("cmp_err_cleared", int'(bus.o_err), 0);
`endif
                end
            end else begin
                check("cmp_idle_done", int'(bus.o_done), 0);
                check("cmp_idle_busy", int'(bus.o_busy), 0);
                check("cmp_hold_x3", int'(bus.o_x3), h_x);
                check("cmp_hold_y3", int'(bus.o_y3), h_y);
                check("cmp_hold_inf3", int'(bus.o_inf3), h_inf);
`ifdef ECC_PT_CHECK_EN
                check("cmp_hold_err", int'(bus.o_err), h_err);
`endif
            end
        end
        if (rst) begin
            m_known = 1'b1; m_pend = 1'b0;
            h_x = 0; h_y = 0; h_inf = 0; h_err = 0;
        end else if (m_known && idle_now && bus.i_start) begin
            model(int'(bus.i_prime), int'(bus.i_a), int'(bus.i_x1), int'(bus.i_y1), int'(bus.i_inf1),
                  int'(bus.i_x2), int'(bus.i_y2), int'(bus.i_inf2), m_x, m_y, m_inf, m_err, m_lat);
            m_k = 0; m_pend = 1'b1; h_err = 0;
        end
    end

    task automatic set_inputs(input int p, input int a, input int x1, input int y1, input int i1,
                              input int x2, input int y2, input int i2);
        bus.i_prime = W'(p);  bus.i_a  = W'(a);
        bus.i_x1 = W'(x1);    bus.i_y1 = W'(y1); bus.i_inf1 = 1'(i1);
        bus.i_x2 = W'(x2);    bus.i_y2 = W'(y2); bus.i_inf2 = 1'(i2);
    endtask

    task automatic run_op(input int p, input int a, input int x1, input int y1, input int i1,
                          input int x2, input int y2, input int i2,
                          output int lat, output int rx, output int ry, output int rinf, output int rerr);
        @(posedge clk); #2;
        set_inputs(p, a, x1, y1, i1, x2, y2, i2);
        bus.i_start = 1'b1;
        @(posedge clk); #2;
        bus.i_start = 1'b0;
        lat = 0; rx = -1; ry = -1; rinf = -1; rerr = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.o_done) begin
                lat = n; rx = int'(bus.o_x3); ry = int'(bus.o_y3); rinf = int'(bus.o_inf3);
`ifdef ECC_PT_CHECK_EN
                rerr = int'(bus.o_err);
`endif
                break;
            end
        end
    endtask

    int vec [5][8] = '{'{13, 2, 1, 4, 0, 6, 9, 0},
                       '{13, 2, 4, 5, 0, 4, 5, 0},
                       '{13, 2, 3, 7, 0, 9, 9, 1},
                       '{11, 1, 0, 0, 1, 5, 1, 1},
                       '{11, 1, 5, 2, 0, 8, 3, 0}};

    initial begin
        int lat, rx, ry, ri, re;
        bit seen;
        bus.i_start = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_x3", int'(bus.o_x3), 0);
        check("rst_y3", int'(bus.o_y3), 0);
        check("rst_inf3", int'(bus.o_inf3), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_done", int'(bus.o_done), 0);

        run_op(11, 1, 2, 7, 0, 2, 7, 0, lat, rx, ry, ri, re);
        check("dbl_lat", lat, 62); check("dbl_x", rx, 5); check("dbl_y", ry, 2); check("dbl_inf", ri, 0);
        run_op(11, 1, 2, 7, 0, 5, 2, 0, lat, rx, ry, ri, re);
        check("add_lat", lat, 57); check("add_x", rx, 8); check("add_y", ry, 3); check("add_inf", ri, 0);
        run_op(11, 1, 2, 7, 0, 2, 4, 0, lat, rx, ry, ri, re);
        check("neg_lat", lat, 2); check("neg_inf", ri, 1);
        run_op(11, 1, 0, 0, 1, 8, 3, 0, lat, rx, ry, ri, re);
        check("inf1_lat", lat, 2); check("inf1_x", rx, 8); check("inf1_y", ry, 3); check("inf1_inf", ri, 0);
        run_op(11, 1, 3, 0, 0, 3, 0, 0, lat, rx, ry, ri, re);
        check("dbl0_lat", lat, 2); check("dbl0_inf", ri, 1);
        run_op(11, 1, 2, 7, 0, 2, 7, 0, lat, rx, ry, ri, re);
        check("b2b_lat", lat, 62); check("b2b_x", rx, 5); check("b2b_y", ry, 2);

        // Abort a doubling with reset; stray starts while busy and alongside reset are ignored
        @(posedge clk); #2;
        set_inputs(11, 1, 2, 7, 0, 2, 7, 0);
        bus.i_start = 1'b1;
        @(posedge clk); #2;
        bus.i_start = 1'b0;
        seen = 1'b0;
        for (int n = 2; n <= 30; n++) begin
            @(posedge clk); #2;
            if (bus.o_done) seen = 1'b1;
            bus.i_start = (n == 5 || n == 12 || n == 19);
            rst = (n == 19);
            if (n == 25) begin
                check("abort_x3", int'(bus.o_x3), 0);
                check("abort_y3", int'(bus.o_y3), 0);
                check("abort_busy", int'(bus.o_busy), 0);
            end
        end
        check("abort_no_done", int'(seen), 0);
        run_op(11, 1, 2, 7, 0, 2, 7, 0, lat, rx, ry, ri, re);
        check("restart_lat", lat, 62); check("restart_x", rx, 5); check("restart_y", ry, 2);

        for (int v = 0; v < 5; v++)
            run_op(vec[v][0], vec[v][1], vec[v][2], vec[v][3], vec[v][4],
                   vec[v][5], vec[v][6], vec[v][7], lat, rx, ry, ri, re);

`ifdef ECC_PT_CHECK_EN
        run_op(11, 1, 12, 7, 0, 2, 7, 0, lat, rx, ry, ri, re);
        check("chk_lat", lat, 2); check("chk_err", re, 1); check("chk_inf", ri, 1); check("chk_x", rx, 0);
        run_op(11, 1, 2, 7, 0, 5, 2, 0, lat, rx, ry, ri, re);
        check("chk_clear_err", re, 0); check("chk_clear_x", rx, 8);
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
